counter_pwm: RTL and testbench
==============================

// Module: counter_pwm
// PURPOSE
//  Downstream PWM stage for the counter block: drives the counter's en and compares its count to a
//  duty value, producing one PWM period per COUNT_FROM..COUNT_TO sweep. Duty takes a valid/ready
//  update that lands only at a period boundary (glitch-free). Start/stop control; stop drains the period.
// PARAMETERS
//  COUNT_WIDTH  3  width of count_in; equals the paired counter's COUNT_WIDTH
//  COUNT_FROM   2  first count of a period; equals the counter's COUNT_FROM
//  COUNT_TO     5  last count of a period; COUNT_TO > COUNT_FROM, else $fatal at elaboration
//  DUTY_WIDTH   $clog2(COUNT_TO-COUNT_FROM+2)  width of duty_data; holds 0..PERIOD
//  DUTY_RESET   0  duty_active/duty_shadow value after reset
//  PWM_POL      1  1: pwm_out high during on-time; 0: output inverted (idle level = !PWM_POL)
// PORTS
//  clk         in   1            clock
//  rst         in   1            reset; synchronous, active-high; shared with the counter
//  count_in    in   COUNT_WIDTH  counter's count output
//  cnt_en      out  1            counter's en input
//  start       in   1            level/pulse: begin generating
//  stop        in   1            level/pulse: finish current period then idle
//  duty_data   in   DUTY_WIDTH   new on-time in counts
//  duty_valid  in   1            duty_data valid
//  duty_ready  out  1            duty update can be accepted
//  pwm_out     out  1            registered PWM output
//  period_done out  1            1-cycle pulse after each completed period
//  busy        out  1            state != IDLE
// BEHAVIOUR
//  - Counter instantiated with ASYNC_RST=0, LOW_RST=0, same clk/rst; invariant: in IDLE count_in==COUNT_FROM.
//  - Reset: state IDLE, cnt_en 0, pwm_out !PWM_POL, period_done 0, duty_ready 1, busy 0, pending 0,
//    duty_active = duty_shadow = DUTY_RESET. rst mid-operation discards pending update and partial period.
//  - PERIOD = COUNT_TO-COUNT_FROM+1. wrap = cnt_en && count_in==COUNT_TO.
//  - FSM IDLE/RUN/DRAIN. cnt_en = (state!=IDLE), decoded from state register.
//    IDLE: start&&!stop -> RUN; stop wins if both. RUN: stop -> DRAIN; start ignored.
//    DRAIN: wrap -> IDLE (counter advances to COUNT_FROM on that edge, then parks); start&&!stop -> RUN.
//  - pwm_out (1-cycle latency): next = PWM_POL ^ !(state!=IDLE && (count_in-COUNT_FROM) < dcl),
//    dcl = min(duty_active, PERIOD). duty 0 -> never on; duty >= PERIOD -> always on.
//    Subtraction at COUNT_WIDTH+1 bits, no wrap; out-of-range count_in treated as off.
//  - period_done: registered, high the cycle after each wrap in RUN or DRAIN.
//  - Duty handshake: accept = duty_valid && duty_ready; duty_ready = !pending.
//    IDLE: accepted value -> duty_active directly; pending stays 0.
//    RUN/DRAIN, no wrap: value -> duty_shadow, pending<=1.
//    wrap && pending: duty_active<=duty_shadow, pending<=0. wrap && accept (pending 0): value -> duty_active.
//    duty_data must be stable while duty_valid && !duty_ready.
// STRUCTURE
//  - counter_pkg: typedef enum logic [1:0] {PWM_IDLE, PWM_RUN, PWM_DRAIN} pwm_state_e;
//    function pwm_period(from,to) returning to-from+1.
//  - Sub-module counter_pwm_duty_reg: shadow/active/pending registers + valid/ready; inputs wrap, idle.
//  - FSM, compare and period_done inline in counter_pwm.
// TESTING (COUNT_WIDTH=3, FROM=2, TO=5, PERIOD=4; DUT paired with counter)
//  1 rst 2 cycles -> pwm_out 0, cnt_en 0, busy 0, duty_ready 1, period_done 0; count_in 2.
//  2 IDLE duty=1, start -> pwm_out 1 for 1 cycle, 0 for 3, repeating; period_done every 4 cycles.
//  3 RUN duty=1, write 3 at count_in=3 -> duty_ready 0 until wrap; next period high 3, low 1.
//  4 duty=0 -> pwm_out constantly 0; duty=7 -> constantly 1 (clamped); PWM_POL=0 inverts both.
//  5 stop at count_in=3 -> cnt_en high through count 5, then IDLE, count parks at 2;
//    repeat with start in DRAIN -> stays running, no idle gap.
//  6 rst mid-RUN with pending update -> reset values next cycle, old duty discarded; start resumes from 2.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types and helpers for the counter and its PWM stage.
// No logic: state encoding and period arithmetic only.
package counter_pkg;

    typedef enum logic [1:0] {
        PWM_IDLE  = 2'd0,
        PWM_RUN   = 2'd1,
        PWM_DRAIN = 2'd2
    } pwm_state_e;

    function automatic int pwm_period(input int from, input int to);
        return to - from + 1;
    endfunction

endpackage

// File: rtl/counter_pwm_duty_reg.sv
// Duty shadow/active registers with valid/ready intake; active changes only at idle or period wrap.
// Latency: one cycle into active (idle/wrap) or shadow; ready drops while a shadow update is pending.
module counter_pwm_duty_reg #(
    parameter int DUTY_WIDTH = 3,
    parameter int DUTY_RESET = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DUTY_WIDTH-1:0] i_duty_data,
    input  logic                  i_duty_valid,
    input  logic                  i_wrap,
    input  logic                  i_idle,
    output logic                  o_duty_ready,
    output logic [DUTY_WIDTH-1:0] o_duty_active
);

    logic [DUTY_WIDTH-1:0] r_active;
    logic [DUTY_WIDTH-1:0] r_shadow;
    logic                  r_pending;
    logic                  w_accept;

    assign w_accept      = i_duty_valid && !r_pending;
    assign o_duty_ready  = !r_pending;
    assign o_duty_active = r_active;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_active  <= DUTY_WIDTH'(DUTY_RESET);
            r_shadow  <= DUTY_WIDTH'(DUTY_RESET);
            r_pending <= 1'b0;
        end else if (i_idle) begin
            if (w_accept) begin
                r_active <= i_duty_data;
            end
            r_pending <= 1'b0;
        end else if (i_wrap) begin
            // Period boundary: a parked value wins; ready is low then, so no same-cycle accept.
            if (r_pending) begin
                r_active <= r_shadow;
            end else if (w_accept) begin
                r_active <= i_duty_data;
            end
            r_pending <= 1'b0;
        end else if (w_accept) begin
            r_shadow  <= i_duty_data;
            r_pending <= 1'b1;
        end
    end

endmodule

// File: rtl/counter_pwm.sv
// PWM stage driving a paired counter's enable; one PWM period per COUNT_FROM..COUNT_TO sweep.
// Output latency one cycle from count_in; duty updates back-pressure until the next period boundary.
module counter_pwm
    import counter_pkg::*;
#(
    parameter int COUNT_WIDTH = 3,
    parameter int COUNT_FROM  = 2,
    parameter int COUNT_TO    = 5,
    parameter int DUTY_WIDTH  = $clog2(COUNT_TO - COUNT_FROM + 2),
    parameter int DUTY_RESET  = 0,
    parameter bit PWM_POL     = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [COUNT_WIDTH-1:0] count_in,
    output logic                   cnt_en,
    input  logic                   start,
    input  logic                   stop,
    input  logic [DUTY_WIDTH-1:0]  duty_data,
    input  logic                   duty_valid,
    output logic                   duty_ready,
    output logic                   pwm_out,
    output logic                   period_done,
    output logic                   busy
);

    localparam int PERIOD = pwm_period(COUNT_FROM, COUNT_TO);
    localparam int OW     = (COUNT_WIDTH + 1 > DUTY_WIDTH) ? COUNT_WIDTH + 1 : DUTY_WIDTH;

    if (COUNT_TO <= COUNT_FROM) begin : g_bad_range
        $fatal(1, "counter_pwm: COUNT_TO must exceed COUNT_FROM");
    end

    pwm_state_e              r_state;
    logic                    r_pwm;
    logic                    r_period_done;
    logic                    w_active;
    logic                    w_wrap;
    logic                    w_on;
    logic [COUNT_WIDTH:0]    w_offset;
    logic [DUTY_WIDTH-1:0]   w_duty_active;
    logic [DUTY_WIDTH-1:0]   w_dcl;

    assign w_active    = (r_state != PWM_IDLE);
    assign cnt_en      = w_active;
    assign busy        = w_active;
    assign pwm_out     = r_pwm;
    assign period_done = r_period_done;
    assign w_wrap      = w_active && (count_in == COUNT_WIDTH'(COUNT_TO));

    // One extra bit keeps a below-range count negative rather than wrapping into the on-window.
    assign w_offset = {1'b0, count_in} - (COUNT_WIDTH + 1)'(COUNT_FROM);
    assign w_dcl    = (w_duty_active > DUTY_WIDTH'(PERIOD)) ? DUTY_WIDTH'(PERIOD) : w_duty_active;
    assign w_on     = w_active && !w_offset[COUNT_WIDTH] && (OW'(w_offset) < OW'(w_dcl));

    counter_pwm_duty_reg #(
        .DUTY_WIDTH (DUTY_WIDTH),
        .DUTY_RESET (DUTY_RESET)
    ) u_duty_reg (
        .clk           (clk),
        .rst           (rst),
        .i_duty_data   (duty_data),
        .i_duty_valid  (duty_valid),
        .i_wrap        (w_wrap),
        .i_idle        (!w_active),
        .o_duty_ready  (duty_ready),
        .o_duty_active (w_duty_active)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= PWM_IDLE;
            r_pwm         <= !PWM_POL;
            r_period_done <= 1'b0;
        end else begin
            r_pwm         <= PWM_POL ^ !w_on;
            r_period_done <= w_wrap;
            unique case (r_state)
                PWM_IDLE: begin
                    if (start && !stop) begin
                        r_state <= PWM_RUN;
                    end
                end
                PWM_RUN: begin
                    if (stop) begin
                        r_state <= PWM_DRAIN;
                    end
                end
                PWM_DRAIN: begin
                    // The counter steps back to COUNT_FROM on this wrap edge and then parks.
                    if (w_wrap) begin
                        r_state <= PWM_IDLE;
                    end else if (start && !stop) begin
                        r_state <= PWM_RUN;
                    end
                end
                default: begin
                    r_state <= PWM_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_pwm.sv
// Bench for counter_pwm paired with a behavioural counter; two DUTs cover both output polarities.
// A period-level reference model is compared every cycle, plus literal waveform checks.
module tb_counter_pwm;

    localparam int CW   = 3;
    localparam int FROM = 2;
    localparam int TO   = 5;
    localparam int PER  = 4;
    localparam int DW   = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          start;
    logic          stop;
    logic          duty_valid;
    logic [DW-1:0] duty_data;
    logic [CW-1:0] cnt0, cnt1;
    logic          en0, en1, rdy0, rdy1, pwm0, pwm1, pd0, pd1, busy0, busy1;

    counter_pwm u_dut (
        .clk(clk), .rst(rst), .count_in(cnt0), .cnt_en(en0), .start(start), .stop(stop),
        .duty_data(duty_data), .duty_valid(duty_valid), .duty_ready(rdy0),
        .pwm_out(pwm0), .period_done(pd0), .busy(busy0)
    );

    counter_pwm #(.PWM_POL(1'b0)) u_dut_inv (
        .clk(clk), .rst(rst), .count_in(cnt1), .cnt_en(en1), .start(start), .stop(stop),
        .duty_data(duty_data), .duty_valid(duty_valid), .duty_ready(rdy1),
        .pwm_out(pwm1), .period_done(pd1), .busy(busy1)
    );

    // Paired counters: sync reset to FROM, step while enabled, wrap TO -> FROM.
    always @(posedge clk) begin
        if (rst) cnt0 <= CW'(FROM);
        else if (en0) cnt0 <= (cnt0 == CW'(TO)) ? CW'(FROM) : cnt0 + CW'(1);
    end
    always @(posedge clk) begin
        if (rst) cnt1 <= CW'(FROM);
        else if (en1) cnt1 <= (cnt1 == CW'(TO)) ? CW'(FROM) : cnt1 + CW'(1);
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check1(input string nm, input logic a, input logic e);
        n_cmp++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", nm, a, e, $time);
        end
    endtask

    task automatic check8(input string nm, input logic [7:0] a, input logic [7:0] e);
        n_cmp++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", nm, a, e, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 run, 2 drain; period position = m_cnt - FROM.
    // The duty in force for a period is fixed at its start; a value accepted mid-period
    // waits (m_wait) and a value accepted on the last cycle goes straight in.
    int m_mode, m_cnt, m_duty, m_wait_val;
    bit m_wait, e_pwm, e_pd, chk_on;

    always @(posedge clk) begin : model
        bit act, wrap, acc;
        int lim, pos;
        if (rst) begin
            m_mode = 0; m_cnt = FROM; m_duty = 0; m_wait = 0; m_wait_val = 0;
            e_pwm = 0; e_pd = 0; chk_on = 1;
        end else begin
            act  = (m_mode != 0);
            wrap = act && (m_cnt == TO);
            pos  = m_cnt - FROM;
            lim  = (m_duty > PER) ? PER : m_duty;
            e_pwm = act && (pos >= 0) && (pos < lim);
            e_pd  = wrap;
            acc   = duty_valid && !m_wait;
            if (!act) begin
                if (acc) m_duty = int'(duty_data);
            end else if (wrap) begin
                if (m_wait) m_duty = m_wait_val;
                else if (acc) m_duty = int'(duty_data);
                m_wait = 0;
            end else if (acc) begin
                m_wait = 1;
                m_wait_val = int'(duty_data);
            end
            if (act) m_cnt = (m_cnt == TO) ? FROM : m_cnt + 1;
            case (m_mode)
                0: if (start && !stop) m_mode = 1;
                1: if (stop) m_mode = 2;
                default: if (wrap) m_mode = 0; else if (start && !stop) m_mode = 1;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check1("pwm",         pwm0,  e_pwm);
            check1("pwm_inv",     pwm1,  !e_pwm);
            check1("cnt_en",      en0,   m_mode != 0);
            check1("cnt_en_inv",  en1,   m_mode != 0);
            check1("busy",        busy0, m_mode != 0);
            check1("busy_inv",    busy1, m_mode != 0);
            check1("ready",       rdy0,  !m_wait);
            check1("ready_inv",   rdy1,  !m_wait);
            check1("period_done", pd0,   e_pd);
            check1("pd_inv",      pd1,   e_pd);
            check8("count",       8'(cnt0), 8'(m_cnt));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cnt(input int v, input string nm);
        int k = 0;
        while (cnt0 != CW'(v) && k < 40) begin
            tick();
            k++;
        end
        if (cnt0 != CW'(v)) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: count %0d never reached, stuck at %0d", nm, v, cnt0);
        end
    endtask

    task automatic write_duty(input int v);
        int k = 0;
        duty_data  = DW'(v);
        duty_valid = 1'b1;
        while (!rdy0 && k < 40) begin
            tick();
            k++;
        end
        if (!rdy0) begin
            n_cmp++;
            n_err++;
            $display("FAIL write_duty: ready stayed %b, expected 1 within 40 cycles", rdy0);
        end
        tick();
        duty_valid = 1'b0;
    endtask

    task automatic cap(input int n, output logic [7:0] p, output logic [7:0] d, output logic [7:0] q);
        p = '0; d = '0; q = '0;
        for (int i = 0; i < n; i++) begin
            p = {p[6:0], pwm0};
            d = {d[6:0], pd0};
            q = {q[6:0], pwm1};
            tick();
        end
    endtask

    logic [7:0] p, d, q;
    logic       held_rdy;

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; duty_valid = 1'b0; duty_data = '0;
        tick(); tick();
        check1("t1_pwm", pwm0, 1'b0);
        check1("t1_pwm_inv", pwm1, 1'b1);
        check1("t1_cnt_en", en0, 1'b0);
        check1("t1_busy", busy0, 1'b0);
        check1("t1_ready", rdy0, 1'b1);
        check1("t1_pd", pd0, 1'b0);
        check8("t1_count", 8'(cnt0), 8'd2);
        rst = 1'b0;

        // Duty 1 from idle: 1 high, 3 low; done pulse once per 4 cycles.
        write_duty(1);
        start = 1'b1; tick(); start = 1'b0;
        tick();
        cap(8, p, d, q);
        check8("t2_pwm", p, 8'b1000_1000);
        check8("t2_pd", d, 8'b0001_0001);
        check8("t2_pwm_inv", q, 8'b0111_0111);

        // Mid-period update to 3 lands at the boundary.
        wait_cnt(3, "t3_sync");
        write_duty(3);
        check1("t3_ready_low", rdy0, 1'b0);
        wait_cnt(2, "t3_wrap");
        check1("t3_ready_back", rdy0, 1'b1);
        tick();
        cap(4, p, d, q);
        check8("t3_pwm", p, 8'b0000_1110);

        write_duty(0);
        wait_cnt(2, "t4_wrap0");
        tick();
        cap(8, p, d, q);
        check8("t4_duty0", p, 8'h00);
        check8("t4_duty0_inv", q, 8'hFF);
        write_duty(7);
        wait_cnt(2, "t4_wrap7");
        tick();
        cap(8, p, d, q);
        check8("t4_duty7", p, 8'hFF);
        check8("t4_duty7_inv", q, 8'h00);

        // Stop drains the period, then parks at FROM.
        write_duty(2);
        wait_cnt(2, "t5_wrap");
        tick();
        stop = 1'b1; tick(); stop = 1'b0;
        check1("t5_en_c4", en0, 1'b1);
        tick();
        check1("t5_en_c5", en0, 1'b1);
        tick();
        check1("t5_en_idle", en0, 1'b0);
        check1("t5_busy_idle", busy0, 1'b0);
        check8("t5_park", 8'(cnt0), 8'd2);
        tick();
        check8("t5_park2", 8'(cnt0), 8'd2);
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        check1("t5_stop_wins", en0, 1'b0);

        // Start during drain keeps running with no idle gap.
        start = 1'b1; tick(); start = 1'b0;
        tick();
        stop = 1'b1; tick(); stop = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        tick();
        check1("t5_no_gap_en", en0, 1'b1);
        check8("t5_no_gap_cnt", 8'(cnt0), 8'd2);
        tick();
        check8("t5_continue", 8'(cnt0), 8'd3);

        // Reset with a pending update discards both old and parked duty.
        write_duty(5);
        check1("t6_pending", rdy0, 1'b0);
        rst = 1'b1; tick(); rst = 1'b0;
        check1("t6_pwm", pwm0, 1'b0);
        check1("t6_en", en0, 1'b0);
        check1("t6_ready", rdy0, 1'b1);
        check8("t6_count", 8'(cnt0), 8'd2);
        start = 1'b1; tick(); start = 1'b0;
        check8("t6_resume", 8'(cnt0), 8'd2);
        cap(5, p, d, q);
        check8("t6_duty_reset", p, 8'h00);
        stop = 1'b1; tick(); stop = 1'b0;

        // Randomised traffic; duty_data held while offered and not yet taken.
        held_rdy = rdy0;
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 99) < 8);
            stop  = ($urandom_range(0, 99) < 6);
            rst   = ($urandom_range(0, 999) < 5);
            if (!(duty_valid && !held_rdy)) begin
                duty_valid = ($urandom_range(0, 3) == 0);
                duty_data  = DW'($urandom_range(0, 7));
            end
            held_rdy = rdy0;
            tick();
        end
        rst = 1'b0; start = 1'b0; stop = 1'b0; duty_valid = 1'b0;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
